// File: rtl/video_ctrl_pkg.sv
// Shared types for the overlay sequencer: display modes and judgment-flash states.
package video_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CAM        = 2'd0,
    MODE_THRESH     = 2'd1,
    MODE_CAM_TGT    = 2'd2,
    MODE_THRESH_TGT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    J_IDLE  = 2'd0,
    J_ARMED = 2'd1,
    J_FLASH = 2'd2
  } jstate_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and zero; clear beats zero beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             zero,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || zero) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/overlay_ctrl.sv
// Overlay mux sequencer: display mode, target enable and judgment flash, all switched
// only on frame boundaries, plus hit/miss/streak scoring.
module overlay_ctrl
  import video_ctrl_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int SCORE_WIDTH  = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   mode_btn_in,
  input  logic                   new_frame_in,
  input  logic                   game_active_in,
  input  logic                   judge_valid_in,
  input  logic                   judge_correct_in,
  input  logic                   score_clr_in,
  output logic [1:0]             mode_out,
  output logic                   bg_out,
  output logic                   target_out,
  output logic                   judgment_out,
  output logic                   judgment_correct_out,
  output logic [SCORE_WIDTH-1:0] hits_out,
  output logic [SCORE_WIDTH-1:0] misses_out,
  output logic [SCORE_WIDTH-1:0] streak_out
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);

  mode_t         pending_mode;
  jstate_t       jstate;
  logic          pend_correct;
  logic          retrig;
  logic [CW-1:0] cnt;
  logic          jv;

  assign jv = judge_valid_in & game_active_in;

  // Mux selects sample pending_mode before any same-cycle button increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_mode <= MODE_CAM;
      mode_out     <= 2'd0;
      bg_out       <= 1'b0;
      target_out   <= 1'b0;
    end else begin
      if (mode_btn_in) pending_mode <= mode_t'(pending_mode + 2'd1);
      if (new_frame_in) begin
        mode_out   <= pending_mode;
        bg_out     <= pending_mode[0];
        target_out <= pending_mode[1] & game_active_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      jstate               <= J_IDLE;
      pend_correct         <= 1'b0;
      retrig               <= 1'b0;
      cnt                  <= '0;
      judgment_out         <= 1'b0;
      judgment_correct_out <= 1'b0;
    end else begin
      if (jv) pend_correct <= judge_correct_in;
      case (jstate)
        J_IDLE: begin
          if (jv) jstate <= J_ARMED;
        end
        J_ARMED: begin
          if (new_frame_in) begin
            judgment_out         <= 1'b1;
            judgment_correct_out <= jv ? judge_correct_in : pend_correct;
            cnt                  <= CW'(FLASH_FRAMES);
            jstate               <= J_FLASH;
          end
        end
        J_FLASH: begin
          if (new_frame_in) begin
            retrig <= 1'b0;
            // A judgment landing on the boundary itself is a retrigger too.
            if (retrig || jv) begin
              cnt                  <= CW'(FLASH_FRAMES);
              judgment_correct_out <= jv ? judge_correct_in : pend_correct;
            end else if (cnt == CW'(1)) begin
              judgment_out <= 1'b0;
              jstate       <= J_IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end else if (jv) begin
            retrig <= 1'b1;
          end
        end
        default: jstate <= J_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(SCORE_WIDTH)) u_hits (
    .clk(clk_in), .rst_n(rst_n_in), .inc(jv & judge_correct_in),
    .clr(score_clr_in), .zero(1'b0), .count(hits_out)
  );

  sat_counter #(.WIDTH(SCORE_WIDTH)) u_misses (
    .clk(clk_in), .rst_n(rst_n_in), .inc(jv & ~judge_correct_in),
    .clr(score_clr_in), .zero(1'b0), .count(misses_out)
  );

  sat_counter #(.WIDTH(SCORE_WIDTH)) u_streak (
    .clk(clk_in), .rst_n(rst_n_in), .inc(jv & judge_correct_in),
    .clr(score_clr_in), .zero(jv & ~judge_correct_in), .count(streak_out)
  );

endmodule

// File: tb/tb_overlay_ctrl.sv
// Directed bench for overlay_ctrl with a frame-level reference model checked every cycle.
module tb_overlay_ctrl;

  localparam int FF  = 3;
  localparam int SW  = 2;
  localparam int SAT = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mb = 1'b0, nf = 1'b0, ga = 1'b0, jv = 1'b0, jc = 1'b0, clr = 1'b0;
  logic [1:0]    mode_out;
  logic          bg_out, target_out, judgment_out, judgment_correct_out;
  logic [SW-1:0] hits_out, misses_out, streak_out;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state: frame-indexed flash window instead of a countdown.
  int  presses, m_mode, m_bg, m_tgt;
  int  frame_idx, flash_end;
  bit  trig_pend, trig_pol, m_jpol;
  int  m_hits, m_misses, m_streak;

  overlay_ctrl #(.FLASH_FRAMES(FF), .SCORE_WIDTH(SW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .mode_btn_in(mb), .new_frame_in(nf),
    .game_active_in(ga), .judge_valid_in(jv), .judge_correct_in(jc),
    .score_clr_in(clr), .mode_out(mode_out), .bg_out(bg_out),
    .target_out(target_out), .judgment_out(judgment_out),
    .judgment_correct_out(judgment_correct_out), .hits_out(hits_out),
    .misses_out(misses_out), .streak_out(streak_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  function automatic bit m_jout();
    return frame_idx < flash_end;
  endfunction

  task automatic model_reset();
    presses = 0; m_mode = 0; m_bg = 0; m_tgt = 0;
    frame_idx = 0; flash_end = 0; trig_pend = 0; trig_pol = 0; m_jpol = 0;
    m_hits = 0; m_misses = 0; m_streak = 0;
  endtask

  task automatic model_step();
    bit jvv;
    bit flashing;
    jvv = jv && ga;
    flashing = m_jout();
    if (nf) begin
      m_mode = presses % 4;
      m_bg   = m_mode % 2;
      m_tgt  = (m_mode / 2) & int'(ga);
      frame_idx++;
      if (trig_pend || (jvv && flashing)) begin
        m_jpol    = jvv ? jc : trig_pol;
        flash_end = frame_idx + FF;
        trig_pend = 0;
        trig_pol  = m_jpol;
      end else if (jvv) begin
        trig_pend = 1; trig_pol = jc;
      end
    end else if (jvv) begin
      trig_pend = 1; trig_pol = jc;
    end
    if (mb) presses++;
    if (clr) begin
      m_hits = 0; m_misses = 0; m_streak = 0;
    end else if (jvv) begin
      if (jc) begin
        m_hits = sat_inc(m_hits); m_streak = sat_inc(m_streak);
      end else begin
        m_misses = sat_inc(m_misses); m_streak = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mode_out", 32'(mode_out), 32'(m_mode));
      check("bg_out", 32'(bg_out), 32'(m_bg));
      check("target_out", 32'(target_out), 32'(m_tgt));
      check("judgment_out", 32'(judgment_out), 32'(m_jout()));
      check("judgment_correct_out", 32'(judgment_correct_out), 32'(m_jpol));
      check("hits_out", 32'(hits_out), 32'(m_hits));
      check("misses_out", 32'(misses_out), 32'(m_misses));
      check("streak_out", 32'(streak_out), 32'(m_streak));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    mb = 0; nf = 0; jv = 0; jc = 0; clr = 0;
  endtask

  task automatic press();
    mb = 1; tick(); tick();
  endtask

  task automatic frame();
    nf = 1; tick(); tick(); tick();
  endtask

  task automatic judge(input bit c);
    jv = 1; jc = c; tick(); tick();
  endtask

  initial begin
    model_reset();
    chk_en = 1;
    repeat (3) tick();
    rst_n = 1;
    tick();
    check("reset_mode", 32'(mode_out), 0);
    check("reset_judgment", 32'(judgment_out), 0);
    ga = 1;

    repeat (3) press();
    frame();
    check("mode3", 32'(mode_out), 3);
    check("mode3_bg", 32'(bg_out), 1);
    check("mode3_tgt", 32'(target_out), 1);
    press();
    frame();
    check("mode_wrap", 32'(mode_out), 0);

    press();
    frame();
    check("mode1", 32'(mode_out), 1);
    mb = 1; nf = 1; tick(); tick();
    check("same_cycle_btn_frame", 32'(mode_out), 1);
    frame();
    check("same_cycle_next_frame", 32'(mode_out), 2);
    press();
    ga = 0;
    frame();
    check("mode3_inactive_tgt", 32'(target_out), 0);
    check("mode3_inactive_mode", 32'(mode_out), 3);
    ga = 1;
    frame();

    judge(0);
    check("armed_not_shown", 32'(judgment_out), 0);
    frame(); check("flash_f1", 32'(judgment_out), 1);
    check("flash_pol", 32'(judgment_correct_out), 0);
    frame(); check("flash_f2", 32'(judgment_out), 1);
    frame(); check("flash_f3", 32'(judgment_out), 1);
    frame(); check("flash_f4_off", 32'(judgment_out), 0);
    frame(); check("flash_f5_off", 32'(judgment_out), 0);
    check("misses_1", 32'(misses_out), 1);
    check("streak_0", 32'(streak_out), 0);

    judge(0);
    frame(); check("rt_f1", 32'(judgment_out), 1);
    frame();
    judge(1);
    check("rt_pol_held", 32'(judgment_correct_out), 0);
    frame(); check("rt_boundary_pol", 32'(judgment_correct_out), 1);
    check("rt_boundary_on", 32'(judgment_out), 1);
    frame(); check("rt_plus1", 32'(judgment_out), 1);
    frame(); check("rt_plus2", 32'(judgment_out), 1);
    frame(); check("rt_plus3_off", 32'(judgment_out), 0);
    check("rt_pol_hold_after", 32'(judgment_correct_out), 1);

    repeat (5) judge(1);
    check("hits_sat", 32'(hits_out), 3);
    check("streak_sat", 32'(streak_out), 3);
    check("misses_2", 32'(misses_out), 2);
    jv = 1; jc = 0; clr = 1; tick(); tick();
    check("clr_hits", 32'(hits_out), 0);
    check("clr_misses", 32'(misses_out), 0);
    check("clr_streak", 32'(streak_out), 0);
    frame();
    check("clr_flash_arms", 32'(judgment_out), 1);
    check("clr_flash_pol", 32'(judgment_correct_out), 0);

    frame();
    #2 rst_n = 0;
    model_reset();
    #1;
    check("async_rst_judgment", 32'(judgment_out), 0);
    check("async_rst_mode", 32'(mode_out), 0);
    check("async_rst_bg", 32'(bg_out), 0);
    check("async_rst_tgt", 32'(target_out), 0);
    repeat (2) tick();
    rst_n = 1;
    tick();
    frame();
    check("post_rst_mode", 32'(mode_out), 0);
    check("post_rst_idle", 32'(judgment_out), 0);
    frame();
    check("post_rst_idle2", 32'(judgment_out), 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
